// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, per-key stability-counter
// debounce FSM, registered debounced level plus single-cycle press/release pulses.
module key_debounce #(
  parameter int unsigned N_KEYS      = 4,
  parameter int unsigned CNT_MAX     = 500000,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned ACTIVE_HIGH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic             REL_LVL  = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] s_c;

  // Synchronisers reset to the released level so a held key re-qualifies after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= {N_KEYS{REL_LVL}};
      sync2_q <= {N_KEYS{REL_LVL}};
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign s_c = (ACTIVE_HIGH != 0) ? sync2_q : ~sync2_q;

  for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_key
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Counter tracks how long s has disagreed with the accepted level.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (s_c[i]) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s_c[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            level_d = 1'b1;
            press_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s_c[i]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (s_c[i]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: run-length debounce model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_key_debounce;

  localparam int N       = 4;
  localparam int CNT_MAX = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] key_in;
  logic [N-1:0] key_level, key_press, key_release;

  int n_checks = 0;
  int n_fail   = 0;

  key_debounce #(
    .N_KEYS(N), .CNT_MAX(CNT_MAX), .CNT_W(4), .ACTIVE_HIGH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a key's level flips once s has disagreed with it for CNT_MAX consecutive edges.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_press, m_rel;
  int           run [N];
  int           cyc;
  int           press_cnt [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0; cyc = 0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      cyc++;
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          run[i]++;
          if (run[i] == CNT_MAX) begin
            m_lvl[i] = ~m_lvl[i];
            if (m_lvl[i]) m_press[i] = 1'b1;
            else          m_rel[i]   = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = key_in;
    end
  end

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the model, plus pulse counting.
  always @(negedge clk) begin
    if (rst_n) begin
      check("level_model", key_level, m_lvl);
      check("press_model", key_press, m_press);
      check("release_model", key_release, m_rel);
      check("press_and_release", key_press & key_release, '0);
      for (int i = 0; i < N; i++) if (key_press[i] === 1'b1) press_cnt[i]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int e0;
  int pc;

  initial begin
    for (int i = 0; i < N; i++) press_cnt[i] = 0;
    rst_n  = 1'b0;
    key_in = '0;
    tick(3);
    check("reset_level", key_level, '0);
    check("reset_press", key_press, '0);
    rst_n = 1'b1;

    // Idle: nothing happens for 50 cycles.
    tick(50);
    check("idle_level", key_level, '0);
    check("idle_press_cnt0", 4'(press_cnt[0]), 4'd0);

    // Clean press on key 0: sampled at edge e0, level rises at e0+9.
    e0 = cyc + 1;
    key_in[0] = 1'b1;
    tick(e0 + 8 - cyc);
    check("clean_pre", key_level, 4'b0000);
    tick(1);
    check("clean_level", key_level, 4'b0001);
    check("clean_press", key_press, 4'b0001);
    tick(1);
    check("clean_press_gone", key_press, 4'b0000);

    // Bounce on key 1, then hold high.
    pc = press_cnt[1];
    key_in[1] = 1'b1; tick(3);
    key_in[1] = 1'b0; tick(3);
    key_in[1] = 1'b1; tick(3);
    key_in[1] = 1'b0; tick(3);
    e0 = cyc + 1;
    key_in[1] = 1'b1;
    tick(e0 + 8 - cyc);
    check("bounce_pre", key_level, 4'b0001);
    tick(1);
    check("bounce_level", key_level, 4'b0011);
    check("bounce_press", key_press, 4'b0010);
    tick(5);
    check("bounce_one_press", 4'(press_cnt[1] - pc), 4'd1);

    // Short release glitch on key 0 is ignored, then a real release.
    key_in[0] = 1'b0; tick(5);
    key_in[0] = 1'b1; tick(15);
    check("glitch_level", key_level, 4'b0011);
    e0 = cyc + 1;
    key_in[0] = 1'b0;
    tick(e0 + 8 - cyc);
    check("release_pre", key_level, 4'b0011);
    tick(1);
    check("release_level", key_level, 4'b0010);
    check("release_pulse", key_release, 4'b0001);
    tick(1);
    check("release_gone", key_release, 4'b0000);

    // Release everything, then press all four together.
    key_in = 4'b0000; tick(20);
    check("all_released", key_level, 4'b0000);
    e0 = cyc + 1;
    key_in = 4'b1111;
    tick(e0 + 9 - cyc);
    check("simul_press", key_press, 4'b1111);
    check("simul_level", key_level, 4'b1111);

    // Async reset during key 2's press qualification.
    key_in[2] = 1'b0; tick(20);
    check("k2_released", key_level, 4'b1011);
    key_in[2] = 1'b1; tick(5);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_level", key_level, 4'b0000);
    check("async_rst_press", key_press | key_release, 4'b0000);
    tick(2);
    rst_n = 1'b1;
    tick(9);
    check("post_rst_pre", key_level, 4'b0000);
    tick(1);
    check("post_rst_press", key_press, 4'b1111);
    check("post_rst_level", key_level, 4'b1111);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
